// File: rtl/decoder_leaf_nway.sv
// decoder_leaf_nway: 1-to-N flit demux with a 1-entry input stage,
// per-port FIFOs and a select-report channel naming each dispatch target.
//
// Ports:
//   CLK, _RESET            clock, synchronous active-low reset
//   in_valid/in_ready      input flit handshake, in_data[SW-1:0] routes
//   out_valid/out_ready    per-port handshake (bit k = port k)
//   out_data               port k at [k*W +: W], flit rotated right by SW
//   s_valid/s_ready/s_data port index of every dispatched flit, in order
//   stat_cnt               saturating per-port dispatch counters, present
//                          only when DECODER_LEAF_STATS_EN is defined
//
// Parameter constraints: W > SW, N a power of 2 >= 2, DEPTH >= 1.
module decoder_leaf_nway #(
    parameter int W     = 9,
    parameter int N     = 2,
    parameter int DEPTH = 2,
    parameter int CW    = 16,
    localparam int SW   = $clog2(N)
) (
    input  logic           CLK,
    input  logic           _RESET,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic [N-1:0]   out_valid,
    input  logic [N-1:0]   out_ready,
    output logic [N*W-1:0] out_data,
    output logic           s_valid,
    input  logic           s_ready,
    output logic [SW-1:0]  s_data
`ifdef DECODER_LEAF_STATS_EN
    ,
    output logic [N*CW-1:0] stat_cnt
`endif
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEPTH);
    localparam logic [PW-1:0]   PTR_MAX = PW'(DEPTH - 1);

    // input stage
    logic          in_full;
    logic [W-1:0]  in_q;
    logic [SW-1:0] sel;
    logic [W-1:0]  rot;
    logic          dispatch;
    logic          in_fire;

    // select-report register
    logic          s_full;
    logic [SW-1:0] s_q;

    // per-port FIFO state
    logic [N-1:0]    fifo_full;
    logic [N-1:0]    push;
    logic [N-1:0]    pop;
    logic [W-1:0]    mem    [N][DEPTH];
    logic [PW-1:0]   wr_ptr [N];
    logic [PW-1:0]   rd_ptr [N];
    logic [CNTW-1:0] cnt    [N];

    assign sel = in_q[SW-1:0];
    // routing field moves to the top so downstream leaves see the next field
    assign rot = {in_q[SW-1:0], in_q[W-1:SW]};

    // fullness is taken from registered occupancy: a pop in the same cycle
    // does not free a slot for the held flit (no full-FIFO bypass)
    assign dispatch = in_full && !fifo_full[sel] && (!s_full || s_ready);
    assign in_ready = !in_full || dispatch;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            in_full <= 1'b0;
            in_q    <= '0;
        end else if (in_fire) begin
            in_full <= 1'b1;
            in_q    <= in_data;
        end else if (dispatch) begin
            in_full <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            s_full <= 1'b0;
            s_q    <= '0;
        end else if (dispatch) begin
            s_full <= 1'b1;
            s_q    <= sel;
        end else if (s_ready) begin
            s_full <= 1'b0;
        end
    end

    assign s_valid = s_full;
    assign s_data  = s_full ? s_q : '0;

    for (genvar p = 0; p < N; p++) begin : g_port
        assign fifo_full[p] = (cnt[p] == CNT_MAX);
        assign push[p]      = dispatch && (sel == SW'(p));
        assign out_valid[p] = (cnt[p] != '0);
        assign pop[p]       = out_valid[p] && out_ready[p];
        // data is forced to zero while empty so reset leaves clean outputs
        assign out_data[p*W +: W] =
            out_valid[p] ? mem[p][rd_ptr[p]] : '0;

        always_ff @(posedge CLK) begin
            if (push[p]) begin
                mem[p][wr_ptr[p]] <= rot;
            end
        end

        always_ff @(posedge CLK) begin
            if (!_RESET) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                cnt[p]    <= '0;
            end else begin
                if (push[p]) begin
                    wr_ptr[p] <= (wr_ptr[p] == PTR_MAX) ?
                                 '0 : wr_ptr[p] + 1'b1;
                end
                if (pop[p]) begin
                    rd_ptr[p] <= (rd_ptr[p] == PTR_MAX) ?
                                 '0 : rd_ptr[p] + 1'b1;
                end
                unique case ({push[p], pop[p]})
                    2'b10:   cnt[p] <= cnt[p] + 1'b1;
                    2'b01:   cnt[p] <= cnt[p] - 1'b1;
                    default: cnt[p] <= cnt[p];
                endcase
            end
        end

`ifdef DECODER_LEAF_STATS_EN
        logic [CW-1:0] stat_q;

        always_ff @(posedge CLK) begin
            if (!_RESET) begin
                stat_q <= '0;
            end else if (push[p] && (stat_q != '1)) begin
                stat_q <= stat_q + 1'b1;
            end
        end

        assign stat_cnt[p*CW +: CW] = stat_q;
`endif
    end

endmodule
